uart_framer: RTL and testbench

UART_FRAMER -- requirements
Module: uart_framer

---
 rtl/uart_framer.sv | 183 ++++++++++++++++++
 tb/tb_uart_framer.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_framer.sv
// uart_framer: turns one group of three 16-bit upstream samples into a UART
// frame of HEADER followed by the six sample bytes (MSB byte first). Each
// byte is sent as 8N1, LSB first, with every bit held CLK_FREQ/BAUD cycles.
// Optional feature macro: UART_FRAMER_CHECKSUM_EN appends an eighth byte
// that is the XOR of the seven preceding bytes, header included.
module uart_framer #(
    parameter int          CLK_FREQ   = 27000000,
    parameter int          BAUD       = 115200,
    parameter int          FETCH_WAIT = 4,
    parameter logic [7:0]  HEADER     = 8'hA5
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        begin_acq,
    input  logic        BRAM_empty,
    input  logic [15:0] data_in_1,
    input  logic [15:0] data_in_2,
    input  logic [15:0] data_in_3,
    output logic        rd_clk,
    output logic        tx,
    output logic        busy,
    output logic [15:0] frames_sent
);

    localparam int DIV = CLK_FREQ / BAUD;
    localparam int BW  = $clog2(DIV);
    localparam int FW  = $clog2(FETCH_WAIT + 1);
    localparam logic [BW-1:0] BAUD_LAST  = BW'(DIV - 1);
    localparam logic [FW-1:0] FETCH_LAST = FW'(FETCH_WAIT - 1);
`ifdef UART_FRAMER_CHECKSUM_EN
    localparam logic [2:0] LAST_BYTE = 3'd7;
`else
    localparam logic [2:0] LAST_BYTE = 3'd6;
`endif

    typedef enum logic [2:0] {
        IDLE, STROBE, FETCH, LOAD, START, DATA, STOP, NEXT
    } state_t;

    state_t        state_q, state_d;
    logic [BW-1:0] baud_q, baud_d;
    logic [2:0]    bit_q, bit_d;
    logic [FW-1:0] wait_q, wait_d;
    logic [2:0]    idx_q, idx_d;
    logic [7:0]    byte_q, byte_d;
    logic [47:0]   buf_q, buf_d;
    logic [15:0]   frames_q, frames_d;
    logic          tx_q, tx_d;
    logic          rd_clk_q, rd_clk_d;
    logic          busy_q, busy_d;
    logic [7:0]    cur_byte;

    // Byte selected for transmission by the current frame position.
    always_comb begin
        cur_byte = HEADER;
        case (idx_q)
            3'd1:    cur_byte = buf_q[47:40];
            3'd2:    cur_byte = buf_q[39:32];
            3'd3:    cur_byte = buf_q[31:24];
            3'd4:    cur_byte = buf_q[23:16];
            3'd5:    cur_byte = buf_q[15:8];
            3'd6:    cur_byte = buf_q[7:0];
`ifdef UART_FRAMER_CHECKSUM_EN
            3'd7:    cur_byte = HEADER ^ buf_q[47:40] ^ buf_q[39:32] ^ buf_q[31:24]
                                       ^ buf_q[23:16] ^ buf_q[15:8]  ^ buf_q[7:0];
`endif
            default: cur_byte = HEADER;
        endcase
    end

    // Next-state logic; outputs are derived from the next state so they are registered.
    always_comb begin
        state_d  = state_q;
        baud_d   = baud_q;
        bit_d    = bit_q;
        wait_d   = wait_q;
        idx_d    = idx_q;
        byte_d   = byte_q;
        buf_d    = buf_q;
        frames_d = frames_q;
        case (state_q)
            IDLE: begin
                idx_d  = 3'd0;
                wait_d = '0;
                if (begin_acq && !BRAM_empty) state_d = STROBE;
            end
            STROBE: begin
                wait_d  = '0;
                state_d = FETCH;
            end
            FETCH: begin
                if (wait_q == FETCH_LAST) begin
                    buf_d   = {data_in_1, data_in_2, data_in_3};
                    state_d = LOAD;
                end else begin
                    wait_d = wait_q + 1'b1;
                end
            end
            LOAD: begin
                byte_d  = cur_byte;
                baud_d  = '0;
                bit_d   = 3'd0;
                state_d = START;
            end
            START: begin
                if (baud_q == BAUD_LAST) begin
                    baud_d  = '0;
                    state_d = DATA;
                end else begin
                    baud_d = baud_q + 1'b1;
                end
            end
            DATA: begin
                if (baud_q == BAUD_LAST) begin
                    baud_d = '0;
                    if (bit_q == 3'd7) state_d = STOP;
                    else               bit_d   = bit_q + 1'b1;
                end else begin
                    baud_d = baud_q + 1'b1;
                end
            end
            STOP: begin
                if (baud_q == BAUD_LAST) begin
                    baud_d  = '0;
                    state_d = NEXT;
                end else begin
                    baud_d = baud_q + 1'b1;
                end
            end
            NEXT: begin
                if (idx_q == LAST_BYTE) begin
                    frames_d = frames_q + 16'd1;
                    state_d  = IDLE;
                end else begin
                    idx_d   = idx_q + 3'd1;
                    state_d = LOAD;
                end
            end
            default: state_d = IDLE;
        endcase

        tx_d = 1'b1;
        if (state_d == START)     tx_d = 1'b0;
        else if (state_d == DATA) tx_d = byte_d[bit_d];
        rd_clk_d = (state_d == STROBE);
        busy_d   = (state_d != IDLE);
    end

    // State and datapath registers; reset forces the line idle immediately.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            baud_q   <= '0;
            bit_q    <= 3'd0;
            wait_q   <= '0;
            idx_q    <= 3'd0;
            byte_q   <= 8'd0;
            buf_q    <= 48'd0;
            frames_q <= 16'd0;
            tx_q     <= 1'b1;
            rd_clk_q <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            baud_q   <= baud_d;
            bit_q    <= bit_d;
            wait_q   <= wait_d;
            idx_q    <= idx_d;
            byte_q   <= byte_d;
            buf_q    <= buf_d;
            frames_q <= frames_d;
            tx_q     <= tx_d;
            rd_clk_q <= rd_clk_d;
            busy_q   <= busy_d;
        end
    end

    assign tx          = tx_q;
    assign rd_clk      = rd_clk_q;
    assign busy        = busy_q;
    assign frames_sent = frames_q;

endmodule

// File: tb/tb_uart_framer.sv
// Bench for uart_framer: a UART receiver monitor decodes tx and checks each
// byte (and its exact bit timing) against a queue of expected bytes that the
// stimulus side pushes whenever it launches a frame.
module tb_uart_framer;

    localparam int         CLK_FREQ = 1000;
    localparam int         BAUD     = 100;
    localparam int         DIV      = CLK_FREQ / BAUD;
    localparam int         FWAIT    = 4;
    localparam logic [7:0] HDR      = 8'hA5;
`ifdef UART_FRAMER_CHECKSUM_EN
    localparam int NB = 8;
`else
    localparam int NB = 7;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        begin_acq = 1'b0;
    logic        BRAM_empty = 1'b1;
    logic [15:0] data_in_1 = 16'd0;
    logic [15:0] data_in_2 = 16'd0;
    logic [15:0] data_in_3 = 16'd0;
    logic        rd_clk;
    logic        tx;
    logic        busy;
    logic [15:0] frames_sent;

    int tests = 0;
    int fails = 0;
    int rx_count = 0;
    int rd_cnt = 0;
    logic [7:0] exp_q[$];

    uart_framer #(
        .CLK_FREQ(CLK_FREQ), .BAUD(BAUD), .FETCH_WAIT(FWAIT), .HEADER(HDR)
    ) dut (
        .clk(clk), .rst_n(rst_n), .begin_acq(begin_acq), .BRAM_empty(BRAM_empty),
        .data_in_1(data_in_1), .data_in_2(data_in_2), .data_in_3(data_in_3),
        .rd_clk(rd_clk), .tx(tx), .busy(busy), .frames_sent(frames_sent)
    );

    always #5 clk = ~clk;

    always @(negedge clk) if (rd_clk) rd_cnt <= rd_cnt + 1;

    // Reference model: the frame is the header, the six sample bytes, and optionally their XOR.
    function automatic void push_frame(input logic [15:0] a, input logic [15:0] b,
                                       input logic [15:0] c);
        logic [7:0] f[8];
        logic [7:0] x;
        f[0] = HDR;
        f[1] = a[15:8]; f[2] = a[7:0];
        f[3] = b[15:8]; f[4] = b[7:0];
        f[5] = c[15:8]; f[6] = c[7:0];
        x = 8'd0;
        for (int i = 0; i < 7; i++) x = x ^ f[i];
        f[7] = x;
        for (int i = 0; i < NB; i++) exp_q.push_back(f[i]);
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got %0h, required %0h", name, act, req);
        end
    endtask

    task automatic pulse_start();
        @(negedge clk);
        begin_acq  = 1'b1;
        BRAM_empty = 1'b0;
        @(negedge clk);
        begin_acq  = 1'b0;
    endtask

    task automatic wait_idle(input int maxc);
        int n;
        n = 0;
        while (busy && n < maxc) begin
            @(negedge clk);
            n++;
        end
        check("idle_reached", 32'(busy), 32'd0);
        repeat (3) @(negedge clk);
    endtask

    task automatic wait_rd(input int maxc, output int n);
        n = 0;
        while (!rd_clk && n < maxc) begin
            @(negedge clk);
            n++;
        end
        check("rd_clk_seen", 32'(rd_clk), 32'd1);
    endtask

    // Monitor: UART receiver sampling every cycle of every bit.
    initial begin
        logic       prev;
        logic [9:0] bits;
        logic       stable;
        logic       aborted;
        logic [7:0] e;
        logic [7:0] d;
        prev = 1'b1;
        forever begin
            @(negedge clk);
            if (rst_n && prev && !tx) begin
                bits = '0; stable = 1'b1; aborted = 1'b0;
                for (int b = 0; b < 10 && !aborted; b++) begin
                    for (int c = 0; c < DIV && !aborted; c++) begin
                        if (b != 0 || c != 0) @(negedge clk);
                        if (!rst_n) aborted = 1'b1;
                        else if (c == 0) bits[b] = tx;
                        else if (tx !== bits[b]) stable = 1'b0;
                    end
                end
                if (!aborted) begin
                    d = bits[8:1];
                    rx_count++;
                    tests++;
                    if (exp_q.size() == 0) begin
                        fails++;
                        $display("FAIL rx_byte: got %02h, required no byte at all", d);
                    end else begin
                        e = exp_q.pop_front();
                        if (d !== e || bits[0] !== 1'b0 || bits[9] !== 1'b1 || !stable) begin
                            fails++;
                            $display("FAIL rx_byte: got %02h start=%0b stop=%0b stable=%0b, required %02h start=0 stop=1 stable=1",
                                     d, bits[0], bits[9], stable, e);
                        end
                    end
                end
            end
            prev = tx;
        end
    end

    initial begin
        int n;
        int base_rd;
        int base_rx;
        int nfr;
        logic bad;

        // Reset state and quiet idle
        #3 rst_n = 1'b0;
        repeat (2) @(negedge clk);
        check("reset_tx", 32'(tx), 32'd1);
        check("reset_rd_clk", 32'(rd_clk), 32'd0);
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_frames", 32'(frames_sent), 32'd0);
        rst_n = 1'b1;
        bad = 1'b0;
        repeat (100) begin
            @(negedge clk);
            if (tx !== 1'b1 || busy !== 1'b0) bad = 1'b1;
        end
        check("idle_quiet_100", 32'(bad), 32'd0);

        // Single frame with known data
        data_in_1 = 16'h147A; data_in_2 = 16'h258B; data_in_3 = 16'h369C;
        push_frame(data_in_1, data_in_2, data_in_3);
        base_rd = rd_cnt; base_rx = rx_count;
        pulse_start();
        BRAM_empty = 1'b1;
        wait_idle(2000);
        check("single_rd_pulses", 32'(rd_cnt - base_rd), 32'd1);
        check("single_bytes", 32'(rx_count - base_rx), 32'(NB));
        check("single_queue_left", 32'(exp_q.size()), 32'd0);
        check("single_frames", 32'(frames_sent), 32'd1);

        // Empty hold, then release
        base_rd = rd_cnt;
        begin_acq = 1'b1; BRAM_empty = 1'b1;
        bad = 1'b0;
        repeat (500) begin
            @(negedge clk);
            if (rd_clk !== 1'b0 || tx !== 1'b1) bad = 1'b1;
        end
        check("empty_hold_quiet", 32'(bad), 32'd0);
        data_in_1 = 16'($urandom); data_in_2 = 16'($urandom); data_in_3 = 16'($urandom);
        push_frame(data_in_1, data_in_2, data_in_3);
        BRAM_empty = 1'b0;
        wait_rd(50, n);
        check("empty_release_latency_le2", 32'(n <= 2), 32'd1);
        begin_acq = 1'b0;
        wait_idle(2000);
        check("empty_frames", 32'(frames_sent), 32'd2);
        check("empty_queue_left", 32'(exp_q.size()), 32'd0);

        // begin_acq dropped during the third byte
        data_in_1 = 16'($urandom); data_in_2 = 16'($urandom); data_in_3 = 16'($urandom);
        push_frame(data_in_1, data_in_2, data_in_3);
        base_rd = rd_cnt; base_rx = rx_count;
        @(negedge clk);
        begin_acq = 1'b1; BRAM_empty = 1'b0;
        n = 0;
        while (rx_count < base_rx + 2 && n < 1000) begin
            @(negedge clk);
            n++;
        end
        check("abort_two_bytes_seen", 32'(rx_count - base_rx), 32'd2);
        repeat (30) @(negedge clk);
        begin_acq = 1'b0;
        wait_idle(2000);
        check("abort_bytes", 32'(rx_count - base_rx), 32'(NB));
        check("abort_frames", 32'(frames_sent), 32'd3);
        repeat (300) @(negedge clk);
        check("abort_no_more_rd", 32'(rd_cnt - base_rd), 32'd1);

        // Back-to-back frames: strobe-to-strobe spacing
        data_in_1 = 16'($urandom); data_in_2 = 16'($urandom); data_in_3 = 16'($urandom);
        push_frame(data_in_1, data_in_2, data_in_3);
        push_frame(data_in_1, data_in_2, data_in_3);
        @(negedge clk);
        begin_acq = 1'b1; BRAM_empty = 1'b0;
        wait_rd(50, n);
        @(negedge clk);
        wait_rd(2000, n);
        check("b2b_strobe_spacing", 32'(n + 1), 32'(1 + FWAIT + NB * (2 + 10 * DIV) + 1));
        begin_acq = 1'b0;
        wait_idle(2000);
        check("b2b_frames", 32'(frames_sent), 32'd5);
        check("b2b_queue_left", 32'(exp_q.size()), 32'd0);

        // Randomised frames with inputs scrambled while the frame is in flight
        nfr = 5;
        for (int k = 0; k < 6; k++) begin
            data_in_1 = 16'($urandom); data_in_2 = 16'($urandom); data_in_3 = 16'($urandom);
            push_frame(data_in_1, data_in_2, data_in_3);
            repeat ($urandom_range(0, 20)) @(negedge clk);
            pulse_start();
            wait_rd(50, n);
            repeat (6) @(negedge clk);
            n = 0;
            while (busy && n < 2000) begin
                data_in_1 = 16'($urandom); data_in_2 = 16'($urandom); data_in_3 = 16'($urandom);
                BRAM_empty = 1'($urandom);
                @(negedge clk);
                n++;
            end
            BRAM_empty = 1'b1;
            wait_idle(10);
            nfr++;
            check("rand_frames", 32'(frames_sent), 32'(nfr));
            check("rand_queue_left", 32'(exp_q.size()), 32'd0);
        end

        // Asynchronous reset during a zero data bit (header bit 1)
        data_in_1 = 16'($urandom); data_in_2 = 16'($urandom); data_in_3 = 16'($urandom);
        push_frame(data_in_1, data_in_2, data_in_3);
        pulse_start();
        wait_rd(50, n);
        repeat (29) @(negedge clk);
        check("pre_reset_tx_zero", 32'(tx), 32'd0);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("async_reset_tx", 32'(tx), 32'd1);
        check("async_reset_busy", 32'(busy), 32'd0);
        check("async_reset_frames", 32'(frames_sent), 32'd0);
        repeat (3) @(negedge clk);
        exp_q.delete();
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        check("post_reset_idle_tx", 32'(tx), 32'd1);
        data_in_1 = 16'($urandom); data_in_2 = 16'($urandom); data_in_3 = 16'($urandom);
        push_frame(data_in_1, data_in_2, data_in_3);
        base_rx = rx_count;
        pulse_start();
        wait_idle(2000);
        check("post_reset_bytes", 32'(rx_count - base_rx), 32'(NB));
        check("post_reset_frames", 32'(frames_sent), 32'd1);
        check("post_reset_queue_left", 32'(exp_q.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
